mem_responder: RTL and testbench



---
 rtl/gpu_mem_pkg.sv | 29 ++
 rtl/mem_responder_channel.sv | 130 +++++++++++++
 rtl/mem_responder.sv | 80 ++++++++
 tb/tb_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional build macro: GPU_DMEM_JITTER_EN (per-channel LFSR latency jitter).
package gpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_RD,
        BUSY_WR,
        RESP,
        WAIT_DROP
    } chan_state_e;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Counter must hold the largest latency plus up to 3 jitter cycles.
    function automatic int unsigned lat_cnt_width(input int unsigned rl, input int unsigned wl);
        int unsigned m;
        m = (rl > wl) ? rl : wl;
        return $clog2(m + 4);
    endfunction

    // Galois step of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, counts out the latency,
// pulses ready once, then waits for the requester to drop valid.
// Optional build macro: GPU_DMEM_JITTER_EN adds 0-3 LFSR-driven extra cycles.
module mem_responder_channel
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE  = 1
`ifdef GPU_DMEM_JITTER_EN
    ,parameter int unsigned CH_INDEX     = 0
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid_i,
    input  logic [ADDR_BITS-1:0] read_address_i,
    input  logic                 write_valid_i,
    input  logic [ADDR_BITS-1:0] write_address_i,
    input  logic [DATA_BITS-1:0] write_data_i,
    input  logic [DATA_BITS-1:0] array_data_i,
    output logic                 read_ready_o,
    output logic [DATA_BITS-1:0] read_data_o,
    output logic                 write_ready_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic [DATA_BITS-1:0] wdata_o,
    output logic                 wr_commit_c
);

    localparam int unsigned CNT_W = lat_cnt_width(READ_LATENCY, WRITE_LATENCY);

    chan_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_wr_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 read_ready_q;
    logic                 write_ready_q;
    logic [DATA_BITS-1:0] read_data_q;
    logic [1:0]           jit;

`ifdef GPU_DMEM_JITTER_EN
    logic [LFSR_W-1:0] lfsr_q;

    // Free-running jitter source, stepped every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED ^ LFSR_W'(CH_INDEX);
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign jit = lfsr_q[1:0];
`else
    assign jit = 2'd0;
`endif

    // Channel FSM with registered ready/data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_wr_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            read_data_q   <= '0;
        end else begin
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (read_valid_i) begin
                        addr_q  <= read_address_i;
                        is_wr_q <= 1'b0;
                        cnt_q   <= CNT_W'(READ_LATENCY - 1) + CNT_W'(jit);
                        state_q <= BUSY_RD;
                    end else if ((WRITE_ENABLE != 0) && write_valid_i) begin
                        addr_q  <= write_address_i;
                        data_q  <= write_data_i;
                        is_wr_q <= 1'b1;
                        cnt_q   <= CNT_W'(WRITE_LATENCY - 1) + CNT_W'(jit);
                        state_q <= BUSY_WR;
                    end
                end
                BUSY_RD: begin
                    if (cnt_q == '0) begin
                        read_ready_q <= 1'b1;
                        read_data_q  <= array_data_i;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                BUSY_WR: begin
                    if (cnt_q == '0) begin
                        write_ready_q <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!(is_wr_q ? write_valid_i : read_valid_i)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The storage write lands on the same edge that raises write ready.
    assign wr_commit_c   = (state_q == BUSY_WR) && (cnt_q == '0) && !reset;
    assign addr_o        = addr_q;
    assign wdata_o       = data_q;
    assign read_ready_o  = read_ready_q;
    assign write_ready_o = write_ready_q;
    assign read_data_o   = read_data_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel data-memory responder: storage array, preload port and
// per-channel request engines. Lowest channel wins same-address writes;
// the load port beats every channel.
// Optional build macro: GPU_DMEM_JITTER_EN (see mem_responder_channel).
module mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    input  logic                    load_valid,
    input  logic [ADDR_BITS-1:0]    load_address,
    input  logic [DATA_BITS-1:0]    load_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0]    mem_q    [DEPTH];
    logic [ADDR_BITS-1:0]    ch_addr  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    ch_wdata [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    ch_rword [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_commit;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign ch_rword[g] = mem_q[ch_addr[g]];

        mem_responder_channel #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .READ_LATENCY  (READ_LATENCY),
            .WRITE_LATENCY (WRITE_LATENCY),
            .WRITE_ENABLE  (WRITE_ENABLE)
`ifdef GPU_DMEM_JITTER_EN
            ,.CH_INDEX     (g)
`endif
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .read_valid_i    (mem_read_valid[g]),
            .read_address_i  (mem_read_address[g]),
            .write_valid_i   (mem_write_valid[g]),
            .write_address_i (mem_write_address[g]),
            .write_data_i    (mem_write_data[g]),
            .array_data_i    (ch_rword[g]),
            .read_ready_o    (mem_read_ready[g]),
            .read_data_o     (mem_read_data[g]),
            .write_ready_o   (mem_write_ready[g]),
            .addr_o          (ch_addr[g]),
            .wdata_o         (ch_wdata[g]),
            .wr_commit_c     (ch_commit[g])
        );
    end

    // Storage update; later assignments win, so iterate high-to-low and load last.
    always_ff @(posedge clk) begin
        for (int c = int'(NUM_CHANNELS) - 1; c >= 0; c--) begin
            if (ch_commit[c]) begin
                mem_q[ch_addr[c]] <= ch_wdata[c];
            end
        end
        if (load_valid) begin
            mem_q[load_address] <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers push expected responses,
// a negedge monitor pops and compares them against DUT ready pulses.
module tb_mem_responder;

    localparam int unsigned AB = 8;
    localparam int unsigned DB = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned RL = 2;
    localparam int unsigned WL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] rd_valid;
    logic [AB-1:0] rd_addr [NC];
    logic [NC-1:0] rd_ready;
    logic [DB-1:0] rd_data [NC];
    logic [NC-1:0] wr_valid;
    logic [AB-1:0] wr_addr [NC];
    logic [DB-1:0] wr_data [NC];
    logic [NC-1:0] wr_ready;
    logic          load_valid;
    logic [AB-1:0] load_address;
    logic [DB-1:0] load_data;

    typedef struct {
        bit            is_wr;
        logic [DB-1:0] data;
        int unsigned   due;
    } exp_t;

    exp_t          exp_q [NC][$];
    exp_t          mon_e;
    logic [DB-1:0] model [256];
    logic [DB-1:0] last_rd [NC];
    int unsigned   cyc = 0;
    logic          rst_s = 1'b1;
    int            checks = 0;
    int            errors = 0;

    mem_responder #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .NUM_CHANNELS  (NC),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL),
        .WRITE_ENABLE  (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rd_valid),
        .mem_read_address  (rd_addr),
        .mem_read_ready    (rd_ready),
        .mem_read_data     (rd_data),
        .mem_write_valid   (wr_valid),
        .mem_write_address (wr_addr),
        .mem_write_data    (wr_data),
        .mem_write_ready   (wr_ready),
        .load_valid        (load_valid),
        .load_address      (load_address),
        .load_data         (load_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: reset-state checks, response matching, read-data hold.
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (rst_s) begin
                check($sformatf("reset_ready ch%0d", c), {30'b0, rd_ready[c], wr_ready[c]}, 32'h0);
                check($sformatf("reset_data ch%0d", c), 32'(rd_data[c]), 32'h0);
                last_rd[c] = '0;
                exp_q[c].delete();
            end else if (rd_ready[c] === 1'b1 || wr_ready[c] === 1'b1) begin
                if (exp_q[c].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready ch%0d at cycle %0d: got rd=%0b wr=%0b expected none",
                             c, cyc, rd_ready[c], wr_ready[c]);
                end else begin
                    mon_e = exp_q[c].pop_front();
                    check($sformatf("kind ch%0d", c), {30'b0, rd_ready[c], wr_ready[c]},
                          mon_e.is_wr ? 32'h1 : 32'h2);
                    check($sformatf("latency ch%0d", c), cyc, mon_e.due);
                    if (!mon_e.is_wr) begin
                        check($sformatf("rdata ch%0d", c), 32'(rd_data[c]), 32'(mon_e.data));
                    end
                end
                if (rd_ready[c] === 1'b1) last_rd[c] = rd_data[c];
            end else begin
                check($sformatf("rdata_hold ch%0d", c), 32'(rd_data[c]), 32'(last_rd[c]));
            end
        end
    end

    // Present a request at a negedge and record its expected response.
    task automatic issue(input int c, input bit is_wr, input logic [AB-1:0] a, input logic [DB-1:0] d);
        exp_t e;
        e.is_wr = is_wr;
        e.data  = model[a];
        e.due   = cyc + 1 + (is_wr ? WL : RL);
        exp_q[c].push_back(e);
        if (is_wr) begin
            wr_valid[c] = 1'b1;
            wr_addr[c]  = a;
            wr_data[c]  = d;
        end else begin
            rd_valid[c] = 1'b1;
            rd_addr[c]  = a;
        end
    endtask

    // Wait (bounded) until every channel in mask has shown its ready pulse, then drop valids.
    task automatic wait_done(input logic [NC-1:0] mask, input bit is_wr);
        logic [NC-1:0] pending;
        int n;
        pending = mask;
        n = 0;
        while (pending != '0 && n < 50) begin
            @(negedge clk);
            n++;
            pending = pending & ~(is_wr ? wr_ready : rd_ready);
        end
        if (pending != '0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got pending=%0h expected 0", pending);
        end
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                if (is_wr) wr_valid[c] = 1'b0;
                else       rd_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic load(input logic [AB-1:0] a, input logic [DB-1:0] d);
        load_valid   = 1'b1;
        load_address = a;
        load_data    = d;
        model[a]     = d;
        @(negedge clk);
        load_valid   = 1'b0;
    endtask

    // Random traffic on one channel, confined to its own address quarter.
    task automatic run_channel(input int ch);
        bit            w;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        @(negedge clk);
        repeat (25) begin
            w = 1'($urandom_range(0, 1));
            a = AB'({2'(ch), 6'($urandom)});
            d = DB'($urandom);
            issue(ch, w, a, d);
            if (w) model[a] = d;
            wait_done(NC'(1) << ch, w);
            repeat ($urandom_range(2, 4)) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        rd_valid   = '0;
        wr_valid   = '0;
        load_valid = 1'b0;
        load_address = '0;
        load_data  = '0;
        for (int c = 0; c < NC; c++) begin
            rd_addr[c] = '0;
            wr_addr[c] = '0;
            wr_data[c] = '0;
            last_rd[c] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Preload the whole array so every read has a known value.
        for (int i = 0; i < 256; i++) load(AB'(i), DB'($urandom));

        // Preloaded read on ch0 with 2-cycle latency.
        load(8'h10, 8'h5A);
        issue(0, 1'b0, 8'h10, 8'h00);
        wait_done(4'b0001, 1'b0);
        repeat (2) @(negedge clk);

        // Write then read back on ch1.
        issue(1, 1'b1, 8'h20, 8'h33);
        model[8'h20] = 8'h33;
        wait_done(4'b0010, 1'b1);
        repeat (2) @(negedge clk);
        issue(1, 1'b0, 8'h20, 8'h00);
        wait_done(4'b0010, 1'b0);
        repeat (2) @(negedge clk);

        // Same-edge writes to one address: ch0 (the lower index) must win.
        issue(0, 1'b1, 8'h40, 8'h11);
        issue(2, 1'b1, 8'h40, 8'h22);
        model[8'h40] = 8'h11;
        wait_done(4'b0101, 1'b1);
        repeat (2) @(negedge clk);
        issue(3, 1'b0, 8'h40, 8'h00);
        wait_done(4'b1000, 1'b0);
        repeat (2) @(negedge clk);

        // All four channels read distinct addresses in the same cycle.
        for (int c = 0; c < NC; c++) issue(c, 1'b0, AB'(8'h80 + c), 8'h00);
        wait_done(4'b1111, 1'b0);
        repeat (2) @(negedge clk);

        // Held valid: one pulse only; a one-cycle drop then re-arms the channel.
        issue(3, 1'b0, 8'h30, 8'h00);
        repeat (10) @(negedge clk);
        rd_valid[3] = 1'b0;
        @(negedge clk);
        issue(3, 1'b0, 8'h30, 8'h00);
        wait_done(4'b1000, 1'b0);
        repeat (2) @(negedge clk);

        // Reset one cycle after accepting a write: no pulse, no commit.
        issue(0, 1'b1, 8'h50, ~model[8'h50]);
        @(negedge clk);
        reset       = 1'b1;
        wr_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue(1, 1'b0, 8'h50, 8'h00);
        issue(2, 1'b0, 8'h10, 8'h00);
        wait_done(4'b0110, 1'b0);
        repeat (2) @(negedge clk);

        // Concurrent random traffic on all channels.
        for (int c = 0; c < NC; c++) begin
            fork
                automatic int ch = c;
                run_channel(ch);
            join_none
        end
        wait fork;

        repeat (6) @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("drain ch%0d", c), 32'(exp_q[c].size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
